i2s_dac_transmitter: RTL
========================

Name: i2s_dac_transmitter

Overview:
- Serialises the mixed audio sample from the mixer into an I2S stream for the board's audio DAC codec.
- Generates BCLK, LRCLK and serial data from the system clock.
- Sends the mono sample on both left and right slots.
- Pulses `sample_tick` once per frame so upstream voice pipelines advance in lock-step with the DAC sample rate.

Parameters:
- AUDIO_BIT_WIDTH, default CONFIG::AUDIO_BIT_WIDTH (24): width of `audio_in`.
- SLOT_WIDTH, default 32: BCLK periods per channel slot. Must be >= AUDIO_BIT_WIDTH.
- BCLK_DIV, default 4: system clocks per BCLK half-period. Must be >= 1.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run request; level-sensitive
- audio_in  input  AUDIO_BIT_WIDTH  mixer output, unsigned offset-binary
- sample_tick  output  1  one-cycle pulse when `audio_in` is latched for a new frame
- busy  output  1  transmitter not IDLE
- bclk  output  1  I2S bit clock
- lrclk  output  1  I2S word select; 0 = left
- dacdat  output  1  I2S serial data, MSB first

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; bclk=0, lrclk=1, dacdat=0, sample_tick=0, busy=0; div_cnt=0; bit_cnt=2*SLOT_WIDTH-1; sample register=0.
- States: IDLE, RUN, DRAIN. busy=1 in RUN and DRAIN.
- IDLE -> RUN when enable=1. div_cnt restarts at 0; bclk starts low.
- div_cnt counts 0..BCLK_DIV-1 in RUN/DRAIN. At BCLK_DIV-1 it wraps and bclk toggles.
- A "falling event" is a toggle from 1 to 0. All lrclk, dacdat and bit_cnt updates happen only on falling events.
- On each falling event: bit_cnt increments modulo 2*SLOT_WIDTH.
  - Wrap to 0: lrclk<=0, `audio_in` latched, sample_tick=1 for that single cycle.
  - bit_cnt becomes SLOT_WIDTH: lrclk<=1.
- Sample conversion: stored value = `audio_in` with MSB inverted (offset-binary to two's complement). 24'h800000 maps to 0.
- Frame word = {S, zeros(SLOT_WIDTH-AUDIO_BIT_WIDTH), S, zeros(...)}, MSB first. Left slot occupies positions 0..SLOT_WIDTH-1.
- Standard I2S: at bit_cnt=k, dacdat = frame word bit position k-1 (one-BCLK delay). At k=0, dacdat = last bit of the previous frame, or 0 for the first frame after IDLE.
- Frame period = 2*SLOT_WIDTH*2*BCLK_DIV clocks. sample_tick fires exactly once per frame.
- RUN -> DRAIN when enable=0.
- DRAIN -> RUN when enable=1, with no discontinuity in bclk or counters.
- DRAIN -> IDLE on the falling event that would wrap bit_cnt to 0. That event does not latch, does not pulse sample_tick and does not toggle lrclk. bclk=0, lrclk=1, dacdat=0 are then held.
- enable rising in the same cycle as the DRAIN->IDLE transition is honoured: IDLE->RUN on the next cycle.
- `audio_in` is sampled only at the latch cycle. Changes at any other time have no effect on the frame in flight.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). No partial frame resumes.

Optional Feature:
- Macro: I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format.
  - Polarity: lrclk=1 marks left.
  - At bit_cnt=0 lrclk<=1; at bit_cnt=SLOT_WIDTH lrclk<=0.
  - Timing: dacdat at bit_cnt=k = frame word bit k (no delay), so the MSB coincides with the lrclk edge.
  - Idle and reset value of lrclk = 0.
- Undefined: standard I2S as described in Behaviour.

Test Plan:
- Common setup for all cases: AUDIO_BIT_WIDTH=24, SLOT_WIDTH=32, BCLK_DIV=2.
1. Reset, enable=1 -> first bclk rise at clock 2, first falling event at clock 4 with sample_tick=1 and lrclk=0; subsequent sample_tick every 256 clocks.
2. audio_in=24'h800001 -> left slot bits (positions 1..32) = 23 zeros, a 1, 8 zeros; right slot identical; lrclk high for bit_cnt 32..63.
3. audio_in=24'hFFFFFF then 24'h000000 -> slots carry 0x7FFFFF then 0x800000; audio_in changed mid-frame does not alter the current frame.
4. Drop enable at bit_cnt=10 -> frame completes through bit_cnt=63, then busy=0, bclk=0, lrclk=1, no extra sample_tick; re-raise enable at bit_cnt=40 of a DRAIN -> no gap, next sample_tick on schedule.
5. Assert reset at bit_cnt=20 -> same cycle bclk=0, lrclk=1, dacdat=0, busy=0; after release with enable=1, timing matches case 1.
6. I2S_LEFT_JUSTIFIED_EN defined, audio_in=24'h800001 -> MSB at bit_cnt=0 with lrclk=1; idle lrclk=0.

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: serialises one mono mixer sample per frame into an
// I2S stream (same sample in left and right slots). BCLK, LRCLK and data are
// all generated from the system clock and registered.
// Optional build macro I2S_LEFT_JUSTIFIED_EN selects left-justified framing
// (lrclk=1 marks left, no one-bit data delay, idle lrclk=0).
//
// state | meaning
// IDLE  | outputs parked, waiting for enable
// RUN   | streaming frames, latching a new sample at every frame start
// DRAIN | enable dropped; finish the frame in flight, then park
module i2s_dac_transmitter #(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int SLOT_WIDTH      = 32,
    parameter int BCLK_DIV        = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [AUDIO_BIT_WIDTH-1:0] audio_in,
    output logic                       sample_tick,
    output logic                       busy,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       dacdat
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BIT_SLOT = BW'(SLOT_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic LR_IDLE = 1'b0;
`else
    localparam logic LR_IDLE = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                     state_q, state_d;
    logic [DW-1:0]              div_q, div_d;
    logic [BW-1:0]              bit_q, bit_d;
    logic                       bclk_q, bclk_d;
    logic                       lrclk_q, lrclk_d;
    logic                       dacdat_q, dacdat_d;
    logic                       tick_q, tick_d;
    logic [AUDIO_BIT_WIDTH-1:0] sample_q, sample_d;
    logic                       primed_q, primed_d;   // a frame has already been sent since IDLE

    logic [BW-1:0]              bit_inc;
    logic [AUDIO_BIT_WIDTH-1:0] audio_conv;

    assign bit_inc    = bit_q + BW'(1);
    // Offset-binary to two's complement: flip the MSB.
    assign audio_conv = {~audio_in[AUDIO_BIT_WIDTH-1], audio_in[AUDIO_BIT_WIDTH-2:0]};

    // Frame word bit at position pos; both slots carry the same sample,
    // left-aligned in the slot with zero padding below the LSB.
    function automatic logic slot_bit(input logic [AUDIO_BIT_WIDTH-1:0] s,
                                      input logic [BW-1:0] pos);
        logic [BW-1:0]              off;
        logic [AUDIO_BIT_WIDTH-1:0] sh;
        off = (pos >= BIT_SLOT) ? pos - BIT_SLOT : pos;
        sh  = s << off;
        return sh[AUDIO_BIT_WIDTH-1];
    endfunction

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= BIT_LAST;
            bclk_q   <= 1'b0;
            lrclk_q  <= LR_IDLE;
            dacdat_q <= 1'b0;
            tick_q   <= 1'b0;
            sample_q <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            dacdat_q <= dacdat_d;
            tick_q   <= tick_d;
            sample_q <= sample_d;
            primed_q <= primed_d;
        end
    end

    // Next-state: BCLK divider, bit counter and serial outputs, all advanced on falling events.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        dacdat_d = dacdat_q;
        tick_d   = 1'b0;
        sample_d = sample_q;
        primed_d = primed_q;

        case (state_q)
            ST_IDLE: begin
                div_d    = '0;
                bit_d    = BIT_LAST;
                bclk_d   = 1'b0;
                lrclk_d  = LR_IDLE;
                dacdat_d = 1'b0;
                primed_d = 1'b0;
                if (enable) state_d = ST_RUN;
            end
            default: begin
                if (state_q == ST_RUN) begin
                    if (!enable) state_d = ST_DRAIN;
                end else begin
                    state_d = enable ? ST_RUN : ST_DRAIN;
                end

                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        if (bit_q == BIT_LAST) begin
                            // Frame boundary wins over a late enable in DRAIN; IDLE
                            // picks enable up again on the following cycle.
                            if (state_q == ST_DRAIN) begin
                                state_d  = ST_IDLE;
                                bit_d    = BIT_LAST;
                                lrclk_d  = LR_IDLE;
                                dacdat_d = 1'b0;
                                primed_d = 1'b0;
                            end else begin
                                bit_d    = '0;
                                lrclk_d  = ~LR_IDLE;
                                sample_d = audio_conv;
                                primed_d = 1'b1;
                                tick_d   = 1'b1;
`ifdef I2S_LEFT_JUSTIFIED_EN
                                dacdat_d = slot_bit(audio_conv, '0);
`else
                                dacdat_d = primed_q & slot_bit(sample_q, BIT_LAST);
`endif
                            end
                        end else begin
                            bit_d = bit_inc;
                            if (bit_inc == BIT_SLOT) lrclk_d = LR_IDLE;
`ifdef I2S_LEFT_JUSTIFIED_EN
                            dacdat_d = slot_bit(sample_q, bit_inc);
`else
                            dacdat_d = slot_bit(sample_q, bit_q);
`endif
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        endcase
    end

    assign sample_tick = tick_q;
    assign busy        = (state_q != ST_IDLE);
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign dacdat      = dacdat_q;

endmodule
